// File: rtl/conv3x3_layer_seq_if.sv
// Handshake and data bundle for the 3x3 convolution layer engine: control,
// window-memory read port and tile output stream.
interface conv3x3_layer_seq_if #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 640,
    parameter int CH      = 3,
    parameter int PIX_PAR = 8,
    parameter int PIX_W   = 8,
    parameter int ACC_W   = 16,
    parameter int ADDR_W  = 20
);
    localparam int TILES  = IMG_W / PIX_PAR;
    localparam int ROW_B  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int TILE_B = (TILES > 1) ? $clog2(TILES) : 1;

    logic                              start;
    logic                              act_en;
    logic [CH*9*PIX_W-1:0]             filter;
    logic                              rd_en;
    logic [ADDR_W-1:0]                 rd_addr;
    logic [3*(PIX_PAR+2)*PIX_W-1:0]    rd_data;
    logic                              out_valid;
    logic                              out_ready;
    logic [PIX_PAR*ACC_W-1:0]          out_data;
    logic [PIX_PAR-1:0]                out_sat;
    logic [ROW_B-1:0]                  out_row;
    logic [TILE_B-1:0]                 out_tile;
    logic                              busy;
    logic                              done;

    modport master (
        input  start, act_en, filter, rd_data, out_ready,
        output rd_en, rd_addr, out_valid, out_data, out_sat, out_row, out_tile, busy, done
    );

    modport slave (
        output start, act_en, filter, rd_data, out_ready,
        input  rd_en, rd_addr, out_valid, out_data, out_sat, out_row, out_tile, busy, done
    );
endinterface

// File: rtl/conv3x3_layer_seq.sv
// Sequential 3x3 convolution layer: one window read per channel per tile,
// PIX_PAR lanes accumulated with saturation, optional ReLU, valid/ready output.
module conv3x3_layer_seq #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 640,
    parameter int CH      = 3,
    parameter int PIX_PAR = 8,
    parameter int PIX_W   = 8,
    parameter int ACC_W   = 16,
    parameter int ADDR_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    conv3x3_layer_seq_if.master   bus
);
    localparam int TILES  = IMG_W / PIX_PAR;
    localparam int ROW_B  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int TILE_B = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int CH_B   = (CH > 1) ? $clog2(CH) : 1;
    localparam int ROWPIX = PIX_PAR + 2;
    localparam int RD_W   = 3 * ROWPIX * PIX_W;
    localparam int TAPS_W = 9 * PIX_W;
    localparam int SUM_W  = 2 * PIX_W + 4;
    localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    localparam logic signed [EXT_W-1:0] ACC_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_LAST, S_OUT, S_DONE} state_t;

    state_t                   state;
    logic [CH_B-1:0]          c;
    logic [ROW_B-1:0]         r, r_nx;
    logic [TILE_B-1:0]        t, t_nx;
    logic                     act_q;
    logic [CH*TAPS_W-1:0]     filt_q;
    logic                     vld_p1;
    logic [CH_B-1:0]          ch_p1;
    logic signed [ACC_W-1:0]  acc [PIX_PAR];
    logic signed [ACC_W-1:0]  acc_nx [PIX_PAR];
    logic [PIX_PAR-1:0]       acc_sat, sat_nx;
    logic                     last_tile;
    logic                     hs;

    function automatic logic [ADDR_W-1:0] win_addr(input logic [CH_B-1:0] ch,
                                                   input logic [ROW_B-1:0] row,
                                                   input logic [TILE_B-1:0] tile);
        int unsigned a;
        a = (int'(ch) * IMG_H + int'(row)) * TILES + int'(tile);
        return ADDR_W'(a);
    endfunction

    // Pixels are zero-extended and weights sign-extended before the MAC.
    function automatic logic signed [SUM_W-1:0] lane_sum(input logic [RD_W-1:0] win,
                                                         input logic [TAPS_W-1:0] w,
                                                         input int lane);
        logic signed [SUM_W-1:0] s, px, wt;
        logic [PIX_W-1:0]        pix, wb;
        s = '0;
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 3; k++) begin
                pix = win[((2 - j) * ROWPIX + (ROWPIX - 1 - lane - k)) * PIX_W +: PIX_W];
                wb  = w[(j * 3 + k) * PIX_W +: PIX_W];
                px  = {{(SUM_W-PIX_W){1'b0}}, pix};
                wt  = {{(SUM_W-PIX_W){wb[PIX_W-1]}}, wb};
                s   = s + px * wt;
            end
        end
        return s;
    endfunction

    // Returns {clamped, value}.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [SUM_W-1:0] b);
        logic signed [EXT_W-1:0] s;
        s = {{(EXT_W-ACC_W){a[ACC_W-1]}}, a} + {{(EXT_W-SUM_W){b[SUM_W-1]}}, b};
        if (s > ACC_MAX)      return {1'b1, ACC_MAX[ACC_W-1:0]};
        else if (s < ACC_MIN) return {1'b1, ACC_MIN[ACC_W-1:0]};
        else                  return {1'b0, s[ACC_W-1:0]};
    endfunction

    function automatic logic [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] a, input logic en);
        return (en && a < 0) ? '0 : a;
    endfunction

    assign last_tile = (r == ROW_B'(IMG_H - 1)) && (t == TILE_B'(TILES - 1));
    assign hs        = (state == S_OUT) && bus.out_ready;

    always_comb begin
        t_nx = t + 1'b1;
        r_nx = r;
        if (t == TILE_B'(TILES - 1)) begin
            t_nx = '0;
            r_nx = r + 1'b1;
        end
    end

    // p1: window data for channel ch_p1 is present; combine into the lanes.
    always_comb begin
        logic [TAPS_W-1:0] w;
        logic [ACC_W:0]    res;
        w   = filt_q[ch_p1 * TAPS_W +: TAPS_W];
        res = '0;
        for (int i = 0; i < PIX_PAR; i++) begin
            res       = sat_add(acc[i], lane_sum(bus.rd_data, w, i));
            acc_nx[i] = res[ACC_W-1:0];
            sat_nx[i] = acc_sat[i] | res[ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.start) filt_q <= bus.filter;
        if ((state == S_IDLE && bus.start) || hs) begin
            for (int i = 0; i < PIX_PAR; i++) acc[i] <= '0;
            acc_sat <= '0;
        end else if (vld_p1) begin
            for (int i = 0; i < PIX_PAR; i++) acc[i] <= acc_nx[i];
            acc_sat <= sat_nx;
        end
    end

    // p0: issue reads and sequence tiles; output registers load at the end of LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            c             <= '0;
            r             <= '0;
            t             <= '0;
            act_q         <= 1'b0;
            vld_p1        <= 1'b0;
            ch_p1         <= '0;
            bus.rd_en     <= 1'b0;
            bus.rd_addr   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= '0;
            bus.out_row   <= '0;
            bus.out_tile  <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            vld_p1   <= bus.rd_en;
            ch_p1    <= c;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        act_q       <= bus.act_en;
                        c           <= '0;
                        r           <= '0;
                        t           <= '0;
                        bus.busy    <= 1'b1;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= win_addr('0, '0, '0);
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (c == CH_B'(CH - 1)) begin
                        bus.rd_en <= 1'b0;
                        state     <= S_LAST;
                    end else begin
                        c           <= c + 1'b1;
                        bus.rd_addr <= win_addr(c + 1'b1, r, t);
                    end
                end
                S_LAST: begin
                    for (int i = 0; i < PIX_PAR; i++) begin
                        bus.out_data[(PIX_PAR-1-i)*ACC_W +: ACC_W] <= relu(acc_nx[i], act_q);
                        bus.out_sat[PIX_PAR-1-i]                   <= sat_nx[i];
                    end
                    bus.out_row   <= r;
                    bus.out_tile  <= t;
                    bus.out_valid <= 1'b1;
                    state         <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (last_tile) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            r           <= r_nx;
                            t           <= t_nx;
                            c           <= '0;
                            bus.rd_en   <= 1'b1;
                            bus.rd_addr <= win_addr('0, r_nx, t_nx);
                            state       <= S_RUN;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv3x3_layer_seq.sv
// Randomised bench for conv3x3_layer_seq against an image-level convolution model.
module tb_conv3x3_layer_seq;
    localparam int IMG_W = 16, IMG_H = 2, CH = 3, PIX_PAR = 8, PIX_W = 8, ACC_W = 16, ADDR_W = 20;
    localparam int TILES = IMG_W / PIX_PAR;
    localparam int NT    = IMG_H * TILES;
    localparam int RD_W  = 3 * (PIX_PAR + 2) * PIX_W;
    localparam int OD_W  = PIX_PAR * ACC_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv3x3_layer_seq_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .PIX_PAR(PIX_PAR),
                           .PIX_W(PIX_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

    conv3x3_layer_seq #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .PIX_PAR(PIX_PAR),
                        .PIX_W(PIX_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int img [CH][IMG_H][IMG_W];
    int wts [CH][9];
    int halo;
    int n_tests = 0;
    int n_fail  = 0;
    logic mem_req = 1'b0;
    int   mem_addr = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pixel(input int c, input int y, input int x);
        if (y < 0 || y >= IMG_H || x < 0 || x >= IMG_W) return halo;
        return img[c][y][x];
    endfunction

    function automatic logic [RD_W-1:0] window(input int a);
        logic [RD_W-1:0] w;
        int c, r, t;
        c = a / (IMG_H * TILES);
        r = (a / TILES) % IMG_H;
        t = a % TILES;
        w = '0;
        for (int j = 0; j < 3; j++)
            for (int p = 0; p < PIX_PAR + 2; p++)
                w[((2 - j) * (PIX_PAR + 2) + (PIX_PAR + 1 - p)) * PIX_W +: PIX_W] =
                    PIX_W'(pixel(c, r - 1 + j, t * PIX_PAR - 1 + p));
        return w;
    endfunction

    // Window memory: a read strobe seen in one cycle yields data in the next.
    always @(negedge clk) begin
        mem_req  = bus.rd_en;
        mem_addr = int'(bus.rd_addr);
    end
    always @(posedge clk) begin
        #1;
        if (mem_req) bus.rd_data = window(mem_addr);
        else         bus.rd_data = RD_W'({8{$urandom}});
    end

    task automatic exp_tile(input int n, input bit act,
                            output logic [OD_W-1:0] d, output logic [PIX_PAR-1:0] s);
        int r, t, acc, sum;
        bit sat;
        r = n / TILES;
        t = n % TILES;
        d = '0;
        s = '0;
        for (int i = 0; i < PIX_PAR; i++) begin
            acc = 0;
            sat = 0;
            for (int c = 0; c < CH; c++) begin
                sum = 0;
                for (int j = 0; j < 3; j++)
                    for (int k = 0; k < 3; k++)
                        sum += pixel(c, r - 1 + j, t * PIX_PAR + i - 1 + k) * wts[c][j * 3 + k];
                acc += sum;
                if (acc > 32767)  begin acc = 32767;  sat = 1; end
                if (acc < -32768) begin acc = -32768; sat = 1; end
            end
            if (act && acc < 0) acc = 0;
            d[(PIX_PAR - 1 - i) * ACC_W +: ACC_W] = ACC_W'(acc);
            s[PIX_PAR - 1 - i] = sat;
        end
    endtask

    task automatic load_filter();
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < 9; k++)
                bus.filter[(c * 9 + k) * PIX_W +: PIX_W] = PIX_W'(wts[c][k]);
    endtask

    task automatic fill_const(input int pix, input int w, input int h);
        for (int c = 0; c < CH; c++) begin
            for (int y = 0; y < IMG_H; y++)
                for (int x = 0; x < IMG_W; x++) img[c][y][x] = pix;
            for (int k = 0; k < 9; k++) wts[c][k] = w;
        end
        halo = h;
        load_filter();
    endtask

    task automatic fill_rand();
        for (int c = 0; c < CH; c++) begin
            for (int y = 0; y < IMG_H; y++)
                for (int x = 0; x < IMG_W; x++) img[c][y][x] = int'($urandom_range(0, 255));
            for (int k = 0; k < 9; k++) wts[c][k] = int'($urandom_range(0, 255)) - 128;
        end
        halo = 0;
        load_filter();
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_rd_en"},     bus.rd_en, 0);
        check_eq({tag, "_rd_addr"},   bus.rd_addr, 0);
        check_eq({tag, "_out_valid"}, bus.out_valid, 0);
        check_eq({tag, "_out_data"},  bus.out_data, 0);
        check_eq({tag, "_out_sat"},   bus.out_sat, 0);
        check_eq({tag, "_out_row"},   bus.out_row, 0);
        check_eq({tag, "_out_tile"},  bus.out_tile, 0);
        check_eq({tag, "_busy"},      bus.busy, 0);
        check_eq({tag, "_done"},      bus.done, 0);
    endtask

    task automatic run_layer(input bit act, input int stall_tile, input int stall_len,
                             input int abort_tile, input bit start_in_done,
                             output logic [OD_W-1:0] d0, output logic [PIX_PAR-1:0] s0);
        int exp_addr[$];
        int nreads, ntile, ndone, stall_cnt, done_k, first_k, held_row, held_tile;
        bit hs_prev, tile_seen;
        logic [OD_W-1:0] ed, held_d;
        logic [PIX_PAR-1:0] es;
        nreads = 0; ntile = 0; ndone = 0; stall_cnt = 0; done_k = -1; first_k = -1;
        held_row = 0; held_tile = 0; hs_prev = 0; tile_seen = 0; held_d = '0;
        d0 = '0; s0 = '0;
        for (int r = 0; r < IMG_H; r++)
            for (int t = 0; t < TILES; t++)
                for (int c = 0; c < CH; c++) exp_addr.push_back((c * IMG_H + r) * TILES + t);

        @(negedge clk);
        bus.act_en    = act;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 1) check_eq("busy_run", bus.busy, 1);
            if (hs_prev) begin
                hs_prev = 0;
                if (ntile < NT) check_eq("rd_after_hs", bus.rd_en, 1);
            end
            if (bus.rd_en) begin
                if (nreads < exp_addr.size()) check_eq("rd_addr", bus.rd_addr, exp_addr[nreads]);
                else check_eq("rd_count", nreads, exp_addr.size());
                if (abort_tile >= 0 && nreads / CH == abort_tile) begin
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    check_reset("abort");
                    @(negedge clk);
                    rst = 1'b0;
                    bus.out_ready = 1'b1;
                    return;
                end
                nreads++;
            end
            if (bus.out_valid) begin
                if (first_k < 0) first_k = k;
                if (!tile_seen) begin
                    tile_seen = 1;
                    exp_tile(ntile, act, ed, es);
                    check_eq("out_data", bus.out_data, ed);
                    check_eq("out_sat", bus.out_sat, es);
                    check_eq("out_row", bus.out_row, ntile / TILES);
                    check_eq("out_tile", bus.out_tile, ntile % TILES);
                    held_d = bus.out_data;
                    held_row = int'(bus.out_row);
                    held_tile = int'(bus.out_tile);
                    if (ntile == 0) begin d0 = bus.out_data; s0 = bus.out_sat; end
                end else begin
                    check_eq("hold_data", bus.out_data, held_d);
                    check_eq("hold_row", bus.out_row, held_row);
                    check_eq("hold_tile", bus.out_tile, held_tile);
                    check_eq("hold_no_rd", bus.rd_en, 0);
                end
                if (ntile == stall_tile && stall_cnt < stall_len) begin
                    bus.out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.out_ready = 1'b1;
                    ntile++;
                    tile_seen = 0;
                    hs_prev = 1;
                end
            end
            if (bus.done) begin
                ndone++;
                if (done_k < 0) done_k = k;
                check_eq("busy_at_done", bus.busy, 0);
                if (start_in_done) bus.start = 1'b1;
            end
            if (done_k > 0 && k > done_k) begin
                check_eq("idle_busy", bus.busy, 0);
                check_eq("idle_rd_en", bus.rd_en, 0);
            end
            if (done_k > 0 && k == done_k + 2) break;
        end
        bus.start = 1'b0;
        check_eq("tiles", ntile, NT);
        check_eq("reads", nreads, NT * CH);
        check_eq("done_count", ndone, 1);
        check_eq("first_valid_cyc", first_k, CH + 2);
        check_eq("done_cyc", done_k, NT * (CH + 2) + 1 + stall_len);
    endtask

    initial begin
        logic [OD_W-1:0] d0;
        logic [PIX_PAR-1:0] s0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.act_en = 1'b0;
        bus.out_ready = 1'b1;
        bus.filter = '0;
        halo = 0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset("post_reset");

        fill_const(1, 1, 1);
        run_layer(1'b0, -1, 0, -1, 1'b1, d0, s0);
        check_eq("ones_lane0", d0[OD_W-1 -: ACC_W], 27);
        check_eq("ones_sat", s0, 0);

        fill_const(1, -1, 1);
        run_layer(1'b0, -1, 0, -1, 1'b0, d0, s0);
        check_eq("neg_lane0", d0[OD_W-1 -: ACC_W], 16'hFFE5);
        run_layer(1'b1, -1, 0, -1, 1'b0, d0, s0);
        check_eq("relu_lane0", d0[OD_W-1 -: ACC_W], 0);

        fill_const(255, 127, 255);
        run_layer(1'b0, -1, 0, -1, 1'b0, d0, s0);
        check_eq("satp_lane0", d0[OD_W-1 -: ACC_W], 16'h7FFF);
        check_eq("satp_flags", s0, 8'hFF);
        fill_const(255, -128, 255);
        run_layer(1'b0, -1, 0, -1, 1'b0, d0, s0);
        check_eq("satn_lane0", d0[OD_W-1 -: ACC_W], 16'h8000);
        check_eq("satn_flags", s0, 8'hFF);

        fill_rand();
        run_layer(1'($urandom_range(0, 1)), 0, 5, -1, 1'b0, d0, s0);

        fill_rand();
        run_layer(1'b0, -1, 0, 2, 1'b0, d0, s0);
        repeat (2) @(negedge clk);
        check_reset("after_abort");
        run_layer(1'b1, -1, 0, -1, 1'b0, d0, s0);

        for (int n = 0; n < 3; n++) begin
            fill_rand();
            run_layer(1'($urandom_range(0, 1)), int'($urandom_range(0, NT - 1)),
                      int'($urandom_range(0, 3)), -1, 1'b0, d0, s0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
